// File: rtl/sample_fifo_if.sv
// Sample FIFO port bundle: host-side push and modulator-side first-word-fall-through pop.
// Adds overflow/underflow when SAMPLE_FIFO_ERR_FLAGS_EN is defined.
interface sample_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  write;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   level;
    logic [DATA_WIDTH-1:0] sample;
    logic                  empty;
    logic                  read;
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    modport master (
        output wr_data, write, read,
        input  full, almost_full, level, sample, empty
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
        , input overflow, underflow
`endif
    );

    modport slave (
        input  wr_data, write, read,
        output full, almost_full, level, sample, empty
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
        , output overflow, underflow
`endif
    );
endinterface

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through sample FIFO between the host side and the modulator.
// Optional sticky overflow/underflow flags are enabled by defining SAMPLE_FIFO_ERR_FLAGS_EN.
module sample_fifo #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned AFULL_LEVEL = 12
) (
    input logic          clk,
    input logic          rst,
    sample_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          do_write, do_read;
    logic          full, empty;

    // Flags come only from registered pointers, never from write/read.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

    always_comb begin
        do_read  = bus.read && !empty;
        // At full a concurrent read frees the very slot being written.
        do_write = bus.write && (!full || do_read);
        wr_ptr_d = wr_ptr_q + PW'(do_write);
        rd_ptr_d = rd_ptr_q + PW'(do_read);
        level_d  = level_q + PW'(do_write) - PW'(do_read);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.level       = level_q;
    assign bus.almost_full = (level_q >= AFULL_THR);
    assign bus.sample      = empty ? '0 : mem[rd_ptr_q[ADDR_WIDTH-1:0]];

`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q || (bus.write && full && !bus.read);
        underflow_d = underflow_q || (bus.read && empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_sample_fifo.sv
// Randomized scoreboard bench for sample_fifo: a queue model tracks contents, a negedge
// monitor compares every observable output and pops on each accepted read.
module tb_sample_fifo;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic clk;
    logic rst;

    sample_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sample_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AFULL_LEVEL(AFL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int         pre_size = 0;
    bit         rd_acc = 0;
    bit         ovf_m = 0;
    bit         udf_m = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare outputs mid-cycle, then retire the head on an accepted read.
    always @(negedge clk) begin
        if (rst) begin
            int sz;
            sz = exp_q.size();
            check("level", 32'(bus.level), 32'(sz));
            check("empty", 32'(bus.empty), 32'(sz == 0));
            check("full", 32'(bus.full), 32'(sz == DEPTH));
            check("almost_full", 32'(bus.almost_full), 32'(sz >= AFL));
            check("sample", 32'(bus.sample), 32'((sz > 0) ? exp_q[0] : 8'h00));
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
            check("overflow", 32'(bus.overflow), 32'(ovf_m));
            check("underflow", 32'(bus.underflow), 32'(udf_m));
`endif
            pre_size = sz;
            rd_acc   = bus.read && (sz > 0);
            if (rd_acc) void'(exp_q.pop_front());
        end
    end

    // Reference model: accept a write if there was room or a read freed a slot.
    always @(posedge clk) begin
        if (rst) begin
            if (bus.write && (pre_size < DEPTH || rd_acc)) exp_q.push_back(bus.wr_data);
            if (bus.write && pre_size == DEPTH && !bus.read) ovf_m = 1;
            if (bus.read && pre_size == 0) udf_m = 1;
        end
    end

    task automatic drive(input bit w, input logic [7:0] d, input bit r);
        bus.write   = w;
        bus.wr_data = d;
        bus.read    = r;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; asserts reset mid-cycle and checks it took effect without an edge.
    task automatic apply_reset();
        bus.write = 0;
        bus.read  = 0;
        #2;
        rst = 0;
        #1;
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_afull", 32'(bus.almost_full), 32'd0);
        check("rst_sample", 32'(bus.sample), 32'd0);
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_underflow", 32'(bus.underflow), 32'd0);
`endif
        exp_q.delete();
        ovf_m    = 0;
        udf_m    = 0;
        pre_size = 0;
        rd_acc   = 0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pw;
        int pr;
        rst         = 1;
        bus.write   = 0;
        bus.read    = 0;
        bus.wr_data = '0;
        #1;
        apply_reset();

        // Single word in and out.
        drive(1, 8'h03, 0);
        check("one_empty", 32'(bus.empty), 32'd0);
        check("one_sample", 32'(bus.sample), 32'h03);
        check("one_level", 32'(bus.level), 32'd1);
        drive(0, 8'h00, 1);
        check("one_rd_empty", 32'(bus.empty), 32'd1);
        check("one_rd_sample", 32'(bus.sample), 32'd0);
        drive(0, 8'h00, 1);
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
        check("udf_set", 32'(bus.underflow), 32'd1);
`endif

        // Fill to full, overflow attempt, drain in order.
        for (int i = 0; i < 16; i++) begin
            drive(1, 8'(i), 0);
            if (i == 10) check("afull_at_11", 32'(bus.almost_full), 32'd0);
            if (i == 11) check("afull_at_12", 32'(bus.almost_full), 32'd1);
        end
        check("fill_full", 32'(bus.full), 32'd1);
        drive(1, 8'hAA, 0);
        check("ovf_level", 32'(bus.level), 32'd16);
        check("ovf_head", 32'(bus.sample), 32'h00);
`ifdef SAMPLE_FIFO_ERR_FLAGS_EN
        check("ovf_set", 32'(bus.overflow), 32'd1);
`endif
        for (int i = 0; i < 16; i++) drive(0, 8'h00, 1);
        check("drain_empty", 32'(bus.empty), 32'd1);

        // Steady-state write+read at level 5 across pointer wrap.
        for (int i = 0; i < 5; i++) drive(1, 8'(8'h40 + i), 0);
        for (int i = 0; i < 40; i++) drive(1, 8'($urandom), 1);
        check("stream_level", 32'(bus.level), 32'd5);
        for (int i = 0; i < 5; i++) drive(0, 8'h00, 1);

        // Write+read at full, then at empty.
        for (int i = 0; i < 16; i++) drive(1, 8'($urandom), 0);
        drive(1, 8'h55, 1);
        check("full_wr_rd_full", 32'(bus.full), 32'd1);
        for (int i = 0; i < 15; i++) drive(0, 8'h00, 1);
        check("full_wr_rd_last", 32'(bus.sample), 32'h55);
        drive(0, 8'h00, 1);
        drive(1, 8'h77, 1);
        check("empty_wr_rd_level", 32'(bus.level), 32'd1);
        check("empty_wr_rd_sample", 32'(bus.sample), 32'h77);
        drive(0, 8'h00, 1);

        // Asynchronous reset mid-burst at level 9.
        for (int i = 0; i < 9; i++) drive(1, 8'(8'hC0 + i), 0);
        check("burst_level", 32'(bus.level), 32'd9);
        apply_reset();
        drive(1, 8'h09, 0);
        check("post_rst_head", 32'(bus.sample), 32'h09);
        check("post_rst_level", 32'(bus.level), 32'd1);

        // Randomized phases with varying write/read bias.
        for (int ph = 0; ph < 4; ph++) begin
            pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
            pr = (ph == 0) ? 20 : (ph == 1) ? 80 : (ph == 2) ? 50 : 95;
            for (int i = 0; i < 600; i++) begin
                drive($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr);
            end
        end
        for (int i = 0; i < 20; i++) drive(0, 8'h00, 1);
        drive(0, 8'h00, 0);
        check("final_empty", 32'(bus.empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sample_fifo.md
SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each stored sample.
REQ-002 Parameter ADDR_WIDTH, default 4: log2 of depth; depth = 2**ADDR_WIDTH (16).
REQ-003 Parameter AFULL_LEVEL, default 12: occupancy at or above which almost_full asserts.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 wr_data  in  DATA_WIDTH  sample from the host/USB side.
REQ-007 write  in  1  push wr_data this cycle.
REQ-008 full  out  1  no free entry.
REQ-009 almost_full  out  1  level >= AFULL_LEVEL.
REQ-010 level  out  ADDR_WIDTH+1  current occupancy, 0..depth.
REQ-011 sample  out  DATA_WIDTH  head-of-queue data for the modulator, first-word-fall-through.
REQ-012 empty  out  1  no valid entry; modulator stalls in idle while high.
REQ-013 read  in  1  modulator pops the head entry this cycle.

Function
REQ-014 The block SHALL be a synchronous FIFO with first-word-fall-through read: sample holds the oldest entry whenever empty=0, with no read latency.
REQ-015 A write with full=0 SHALL store wr_data at wr_ptr and advance wr_ptr on that edge; empty SHALL deassert and sample SHALL show the word in the cycle after the edge (1-cycle write-to-read latency).
REQ-016 A read with empty=0 SHALL advance rd_ptr on that edge; the next entry, or empty=1, SHALL appear in the following cycle.
REQ-017 write while full=1 and read=0 SHALL be ignored: no pointer, memory, or level change.
REQ-018 read while empty=1 SHALL be ignored: no pointer or level change.
REQ-019 Simultaneous write and read with 0 < level < depth SHALL perform both; level unchanged.
REQ-020 Simultaneous write and read at full=1 SHALL perform both; full stays 1 and the written word lands in the slot freed by the read.
REQ-021 Simultaneous write and read at empty=1 SHALL accept only the write; level becomes 1.
REQ-022 Pointers SHALL be ADDR_WIDTH+1 bits, wrapping modulo 2*depth; empty = (wr_ptr == rd_ptr); full = MSBs differ and low ADDR_WIDTH bits equal.
REQ-023 level SHALL equal wr_ptr - rd_ptr modulo 2**(ADDR_WIDTH+1), registered together with the pointers.
REQ-024 full, empty and almost_full SHALL be derived only from registered pointers, with no combinational path from write or read.
REQ-025 sample SHALL be driven to 0 while empty=1.
REQ-026 The memory array SHALL not be reset; only pointers and flags are.

Reset
REQ-027 While rst=0: wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, almost_full=0, sample=0, immediately and independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries; the first write after release SHALL become the head.
REQ-029 Reset release SHALL take effect on the first rising clk edge after rst returns to 1; write or read in that cycle is honoured.

Configuration
REQ-030 Macro SAMPLE_FIFO_ERR_FLAGS_EN: when defined, add outputs overflow (1) and underflow (1), sticky, set by a write ignored under REQ-017 or a read ignored under REQ-018, cleared only by reset; reset value 0.
REQ-031 Without SAMPLE_FIFO_ERR_FLAGS_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset, then write 8'h03 one cycle -> next cycle empty=0, sample=8'h03, level=1; one-cycle read -> empty=1, sample=0.
REQ-033 Write 16 words 8'h00..8'h0F with no reads -> almost_full at level 12, full at 16; 17th write 8'hAA ignored; 16 reads return 8'h00..8'h0F in order.
REQ-034 Hold write=read=1 for 40 cycles at level 5 -> level stays 5, output order preserved across pointer wrap.
REQ-035 At full, write 8'h55 with read=1 -> full stays 1, head advances, 8'h55 is read last; at empty, write 8'h77 with read=1 -> level=1, sample=8'h77.
REQ-036 Pull rst low mid-burst at level 9, asynchronously to clk -> empty=1, level=0 before the next edge; post-release write 8'h09 is the head.
REQ-037 With SAMPLE_FIFO_ERR_FLAGS_EN: read at empty -> underflow=1 and held; write at full -> overflow=1 and held; both clear only on rst=0.
